// File: rtl/ov5640_cfg_pkg.sv
// Shared constants, table entry type and bring-up register table for the
// OV5640 configuration sequencer.
package ov5640_cfg_pkg;

    localparam int OV_REG_NUM = 285;
    localparam int OV_IDX_W   = 9;

    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_WRITE = 4'b0010;
    localparam logic [3:0] CMD_READ  = 4'b0100;
    localparam logic [3:0] CMD_STOP  = 4'b1000;

    localparam logic [7:0]  OV_WR_ID     = 8'h78;
    localparam logic [7:0]  OV_RD_ID     = 8'h79;
    localparam logic [15:0] OV_SYS_CTRL0 = 16'h3008;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } cfg_entry_t;

    // Sensor bring-up sequence; slots past the listed block replay the
    // normal-mode system-control write, which is idempotent.
    function automatic cfg_entry_t ov5640_rom_entry(input logic [OV_IDX_W-1:0] idx);
        cfg_entry_t e;
        case (idx)
            9'd0:  e = 24'h310311;
            9'd1:  e = 24'h300882;
            9'd2:  e = 24'h300842;
            9'd3:  e = 24'h310303;
            9'd4:  e = 24'h3017ff;
            9'd5:  e = 24'h3018ff;
            9'd6:  e = 24'h30341a;
            9'd7:  e = 24'h303713;
            9'd8:  e = 24'h310801;
            9'd9:  e = 24'h363036;
            9'd10: e = 24'h36310e;
            9'd11: e = 24'h3632e2;
            9'd12: e = 24'h363312;
            9'd13: e = 24'h3621e0;
            9'd14: e = 24'h3704a0;
            9'd15: e = 24'h37035a;
            9'd16: e = 24'h371578;
            9'd17: e = 24'h371701;
            9'd18: e = 24'h370b60;
            9'd19: e = 24'h37051a;
            9'd20: e = 24'h390502;
            9'd21: e = 24'h390610;
            9'd22: e = 24'h39010a;
            9'd23: e = 24'h373112;
            9'd24: e = 24'h360008;
            9'd25: e = 24'h360133;
            9'd26: e = 24'h302d60;
            9'd27: e = 24'h362052;
            9'd28: e = 24'h371b20;
            9'd29: e = 24'h471c50;
            9'd30: e = 24'h3a1343;
            9'd31: e = 24'h3a1800;
            9'd32: e = 24'h3a19f8;
            9'd33: e = 24'h363513;
            9'd34: e = 24'h363603;
            9'd35: e = 24'h363440;
            9'd36: e = 24'h362201;
            default: e = {OV_SYS_CTRL0, 8'h02};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ov5640_cfg_rom.sv
// OV5640 register table as an inferred ROM with a registered read port
// (one cycle from address to data).
module ov5640_cfg_rom
    import ov5640_cfg_pkg::*;
(
    input  logic                clk,
    input  logic [OV_IDX_W-1:0] addr,
    output logic [23:0]         data
);

    localparam logic [OV_IDX_W-1:0] LAST_ADDR = OV_IDX_W'(OV_REG_NUM - 1);

    logic [23:0] rom_mem [OV_REG_NUM];
    logic [23:0] data_q;

    generate
        for (genvar gi = 0; gi < OV_REG_NUM; gi++) begin : g_rom
            assign rom_mem[gi] = ov5640_rom_entry(OV_IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        data_q <= (addr <= LAST_ADDR) ? rom_mem[addr] : 24'h0;
    end

    assign data = data_q;

endmodule

// File: rtl/ov5640_cfg_ctrl.sv
// Walks the OV5640 register table and issues each entry as a four-byte I2C
// write through the byte engine, retrying NACKed registers.
module ov5640_cfg_ctrl
    import ov5640_cfg_pkg::*;
#(
    parameter int         REG_NUM   = OV_REG_NUM,
    parameter int         IDX_W     = OV_IDX_W,
    parameter int         INIT_DLY  = 1000000,
    parameter int         SWRST_DLY = 250000,
    parameter int         MAX_RETRY = 3,
    parameter logic [7:0] WR_ID     = OV_WR_ID
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    output logic [IDX_W-1:0] cfg_index,
    input  logic [23:0]      cfg_data,
    output logic             req,
    output logic [3:0]       cmd,
    output logic [7:0]       dout,
    input  logic             done,
    input  logic             slave_ack,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] err_index
);

    localparam logic [3:0] S_PWR_WAIT   = 4'd0;
    localparam logic [3:0] S_LOAD       = 4'd1;
    localparam logic [3:0] S_REQ        = 4'd2;
    localparam logic [3:0] S_WAIT       = 4'd3;
    localparam logic [3:0] S_CHECK      = 4'd4;
    localparam logic [3:0] S_SWRST_WAIT = 4'd5;
    localparam logic [3:0] S_NEXT       = 4'd6;
    localparam logic [3:0] S_DONE       = 4'd7;
    localparam logic [3:0] S_FAIL       = 4'd8;

    localparam int               RTY_W      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] MAX_RTY    = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_ONE    = RTY_W'(1);
    localparam logic [19:0]      INIT_LAST  = 20'(INIT_DLY - 1);
    localparam logic [19:0]      SWRST_LAST = 20'(SWRST_DLY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(REG_NUM - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    logic [3:0]       state_q,    state_d;
    logic [19:0]      cnt_q,      cnt_d;
    logic             load_ph_q,  load_ph_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic             nack_q,     nack_d;
    logic [RTY_W-1:0] retry_q,    retry_d;
    cfg_entry_t       shadow_q,   shadow_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic             req_q,      req_d;
    logic [3:0]       cmd_q,      cmd_d;
    logic [7:0]       dout_q,     dout_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;
    logic [IDX_W-1:0] err_idx_q,  err_idx_d;

    always_comb begin
        state_d    = state_q;
        load_ph_d  = load_ph_q;
        byte_cnt_d = byte_cnt_q;
        nack_d     = nack_q;
        retry_d    = retry_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        req_d      = 1'b0;
        cmd_d      = cmd_q;
        dout_d     = dout_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        err_idx_d  = err_idx_q;

        case (state_q)
            S_PWR_WAIT: begin
                busy_d    = 1'b1;
                load_ph_d = 1'b0;
                if (cnt_q == INIT_LAST) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (!load_ph_q) begin
                    load_ph_d = 1'b1;
                end else begin
                    load_ph_d  = 1'b0;
                    shadow_d   = cfg_data;
                    nack_d     = 1'b0;
                    byte_cnt_d = 2'd0;
                    req_d      = 1'b1;
                    cmd_d      = CMD_START | CMD_WRITE;
                    dout_d     = WR_ID;
                    state_d    = S_REQ;
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    nack_d = nack_q | slave_ack;
                    if (byte_cnt_q != 2'd3) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        req_d      = 1'b1;
                        state_d    = S_REQ;
                        // byte_cnt_q is the byte just completed; load the next one
                        case (byte_cnt_q)
                            2'd0: begin
                                cmd_d  = CMD_WRITE;
                                dout_d = shadow_q.addr[15:8];
                            end
                            2'd1: begin
                                cmd_d  = CMD_WRITE;
                                dout_d = shadow_q.addr[7:0];
                            end
                            default: begin
                                cmd_d  = CMD_WRITE | CMD_STOP;
                                dout_d = shadow_q.data;
                            end
                        endcase
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (nack_q) begin
                    if (retry_q < MAX_RTY) begin
                        retry_d = retry_q + RTY_ONE;
                        state_d = S_LOAD;
                    end else begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        busy_d    = 1'b0;
                        state_d   = S_FAIL;
                    end
                end else if (shadow_q.addr == OV_SYS_CTRL0 && shadow_q.data[7]) begin
                    state_d = S_SWRST_WAIT;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_SWRST_WAIT: begin
                if (cnt_q == SWRST_LAST) state_d = S_NEXT;
            end
            S_NEXT: begin
                retry_d = '0;
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_LOAD;
                end
            end
            S_DONE, S_FAIL: begin
                busy_d = 1'b0;
                if (cfg_start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    retry_d = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_PWR_WAIT;
        endcase
    end

    // Delay counter restarts on every state change and saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (cnt_q != 20'hFFFFF) cnt_d = cnt_q + 20'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PWR_WAIT;
            cnt_q      <= '0;
            load_ph_q  <= 1'b0;
            byte_cnt_q <= '0;
            nack_q     <= 1'b0;
            retry_q    <= '0;
            shadow_q   <= '0;
            idx_q      <= '0;
            req_q      <= 1'b0;
            cmd_q      <= '0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            load_ph_q  <= load_ph_d;
            byte_cnt_q <= byte_cnt_d;
            nack_q     <= nack_d;
            retry_q    <= retry_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
            req_q      <= req_d;
            cmd_q      <= cmd_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_idx_q  <= err_idx_d;
        end
    end

    assign cfg_index = idx_q;
    assign req       = req_q;
    assign cmd       = cmd_q;
    assign dout      = dout_q;
    assign busy      = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_index = err_idx_q;

endmodule

// File: tb/tb_ov5640_cfg_ctrl.sv
// Bench for ov5640_cfg_ctrl: table model, byte-engine model with fixed
// latency and scripted NACKs, vector table plus directed corner sequences.
module tb_ov5640_cfg_ctrl;
    import ov5640_cfg_pkg::*;

    localparam int INIT_DLY  = 10;
    localparam int SWRST_DLY = 5;
    localparam int NREG      = 3;
    localparam int ENG_LAT   = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [8:0]  cfg_index;
    logic [23:0] cfg_data;
    logic        req;
    logic [3:0]  cmd;
    logic [7:0]  dout;
    logic        done;
    logic        slave_ack;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [8:0]  err_index;

    logic [8:0]  rom_addr = 9'd1;
    logic [23:0] rom_data;

    ov5640_cfg_ctrl #(
        .REG_NUM(NREG), .IDX_W(9), .INIT_DLY(INIT_DLY),
        .SWRST_DLY(SWRST_DLY), .MAX_RETRY(3), .WR_ID(8'h78)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_index(cfg_index),
        .cfg_data(cfg_data), .req(req), .cmd(cmd), .dout(dout), .done(done),
        .slave_ack(slave_ack), .busy(busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .err_index(err_index)
    );

    ov5640_cfg_rom rom (.clk(clk), .addr(rom_addr), .data(rom_data));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Register table model with one cycle of read latency.
    logic [23:0] tbl [NREG];
    always @(posedge clk) cfg_data <= (cfg_index < 9'(NREG)) ? tbl[cfg_index[1:0]] : 24'h0;

    // Byte-engine model.
    int         mode = 0;
    int         eng_cnt, req_cnt, viol, pos, cur_ent;
    int         att [NREG];
    logic [7:0] hi_b;
    logic       ack_pend;
    logic [3:0] log_cmd  [64];
    logic [7:0] log_dout [64];
    int         p_now, e_now;
    logic       nack_now;

    function automatic int ent_of(input logic [15:0] a);
        for (int k = 0; k < NREG; k++) if (tbl[k][23:8] == a) return k;
        return NREG;
    endfunction

    assign p_now = cmd[0] ? 0 : pos + 1;
    always_comb begin
        e_now    = (p_now == 2) ? ent_of({hi_b, dout}) : cur_ent;
        nack_now = 1'b0;
        if (mode == 1 && p_now == 2 && e_now == 1 && att[1] == 0) nack_now = 1'b1;
        if (mode == 2 && p_now == 3 && e_now == 2) nack_now = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt   <= 0;
            done      <= 1'b0;
            slave_ack <= 1'b0;
            req_cnt   <= 0;
            viol      <= 0;
            pos       <= 0;
            cur_ent   <= NREG;
            hi_b      <= 8'h0;
            ack_pend  <= 1'b0;
            for (int k = 0; k < NREG; k++) att[k] <= 0;
        end else begin
            done <= 1'b0;
            if (req) begin
                if (eng_cnt != 0) viol <= viol + 1;
                eng_cnt <= ENG_LAT;
                if (req_cnt < 64) begin
                    log_cmd[req_cnt]  <= cmd;
                    log_dout[req_cnt] <= dout;
                end
                req_cnt  <= req_cnt + 1;
                pos      <= p_now;
                ack_pend <= nack_now;
                if (p_now == 1) hi_b <= dout;
                if (p_now == 2) cur_ent <= e_now;
                if (p_now == 3 && e_now < NREG) att[e_now] <= att[e_now] + 1;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) begin
                    done      <= 1'b1;
                    slave_ack <= ack_pend;
                end
            end
        end
    end

    // Timestamps: last done of entry 0 and the index step from 0 to 1.
    int         ncyc = 0;
    int         t_done0 = 0;
    int         t_idx1 = 0;
    logic [8:0] idx_prev = 9'd0;
    always @(negedge clk) begin
        ncyc     <= ncyc + 1;
        idx_prev <= cfg_index;
        if (done && pos == 3 && cur_ent == 0) t_done0 <= ncyc;
        if (idx_prev == 9'd0 && cfg_index == 9'd1) t_idx1 <= ncyc;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Waits for the next req; returns the number of negedges elapsed, or -1.
    task automatic first_req(input int limit, output int c_out);
        c_out = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (c == 1) chk("busy_after_start", 32'(busy), 32'd1);
            if (req) begin
                c_out = c;
                break;
            end
        end
    endtask

    task automatic wait_end(input int limit);
        int c;
        c = 0;
        while (!(cfg_done || cfg_err) && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("run_finished", 32'(cfg_done | cfg_err), 32'd1);
    endtask

    typedef struct {
        logic [23:0] e0, e1, e2;
        int          mode;
        int          exp_req;
        logic        exp_done;
        logic        exp_err;
        logic [8:0]  exp_eidx;
        int          exp_gap;
    } vec_t;

    vec_t vecs [4];
    int   fr, base;

    initial begin
        // Entry-0 done to index step: CHECK, NEXT, then LOAD (+ soft-reset wait).
        vecs[0] = '{24'h300812, 24'h300E58, 24'h310311, 0, 12, 1'b1, 1'b0, 9'd0, 3};
        vecs[1] = '{24'h300882, 24'h300E58, 24'h310311, 0, 12, 1'b1, 1'b0, 9'd0, 3 + SWRST_DLY};
        vecs[2] = '{24'h300812, 24'h300E58, 24'h310311, 1, 16, 1'b1, 1'b0, 9'd0, 3};
        vecs[3] = '{24'h300812, 24'h300E58, 24'h310311, 2, 24, 1'b0, 1'b1, 9'd2, 3};

        for (int i = 0; i < 4; i++) begin
            tbl[0] = vecs[i].e0;
            tbl[1] = vecs[i].e1;
            tbl[2] = vecs[i].e2;
            mode   = vecs[i].mode;
            rst_n  = 1'b0;
            repeat (2) @(negedge clk);
            chk("reset_req_cmd_dout", {19'd0, req, cmd, dout}, 32'd0);
            chk("reset_status", {11'd0, cfg_index, busy, cfg_done, cfg_err, err_index}, 32'd0);
            if (i == 0) chk("rom_entry1", {8'd0, rom_data}, {8'd0, 24'h300882});
            rst_n = 1'b1;
            first_req(200, fr);
            chk("first_req_cycle", 32'(fr), 32'(INIT_DLY + 2));
            wait_end(3000);
            repeat (60) @(negedge clk);
            chk("req_count", 32'(req_cnt), 32'(vecs[i].exp_req));
            chk("cfg_done", 32'(cfg_done), 32'(vecs[i].exp_done));
            chk("cfg_err", 32'(cfg_err), 32'(vecs[i].exp_err));
            chk("err_index", 32'(err_index), 32'(vecs[i].exp_eidx));
            chk("busy_idle", 32'(busy), 32'd0);
            chk("engine_rule", 32'(viol), 32'd0);
            chk("entry0_gap", 32'(t_idx1 - t_done0), 32'(vecs[i].exp_gap));
            if (vecs[i].mode == 0) begin
                for (int k = 0; k < 12; k++) begin
                    logic [3:0] ec;
                    logic [7:0] ed;
                    logic [23:0] ent;
                    ent = tbl[k / 4];
                    case (k % 4)
                        0: begin ec = 4'b0011; ed = 8'h78;       end
                        1: begin ec = 4'b0010; ed = ent[23:16]; end
                        2: begin ec = 4'b0010; ed = ent[15:8];  end
                        default: begin ec = 4'b1010; ed = ent[7:0]; end
                    endcase
                    chk($sformatf("byte%0d_cmd_dout", k), {20'd0, log_cmd[k], log_dout[k]}, {20'd0, ec, ed});
                end
            end
            $display("[TB] vec %0d: req=%0d done=%0b err=%0b eidx=%0d gap=%0d",
                     i, req_cnt, cfg_done, cfg_err, err_index, t_idx1 - t_done0);
        end

        // cfg_start from FAIL restarts at index 0 without the power-up wait.
        mode      = 0;
        base      = req_cnt;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("restart_err_clear", 32'(cfg_err), 32'd0);
        chk("restart_index", 32'(cfg_index), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        fr = -1;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (req) begin
                fr = c;
                break;
            end
        end
        chk("restart_first_req", 32'(fr), 32'd3);
        for (int c = 0; c < 500 && cfg_index != 9'd1; c++) @(negedge clk);
        chk("reached_index1", 32'(cfg_index), 32'd1);
        repeat (4) @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_start_ignored", 32'(cfg_index), 32'd1);
        wait_end(3000);
        chk("restart_done", 32'(cfg_done), 32'd1);
        chk("restart_req_count", 32'(req_cnt - base), 32'd12);
        $display("[TB] restart: req=%0d done=%0b", req_cnt - base, cfg_done);

        // Asynchronous reset between the byte-1 req and its done.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 200 && req_cnt < 2; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("midframe_cmd_dout", {20'd0, cmd, dout}, {20'd0, 4'b0010, 8'h30});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_cmd_dout", {19'd0, req, cmd, dout}, 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        first_req(200, fr);
        chk("post_rst_first_req", 32'(fr), 32'(INIT_DLY + 2));
        wait_end(3000);
        chk("post_rst_req_count", 32'(req_cnt), 32'd12);
        chk("post_rst_entry0", {log_dout[0], log_dout[1], log_dout[2], log_dout[3]}, 32'h78300812);
        $display("[TB] async reset: req=%0d done=%0b", req_cnt, cfg_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
